gfx_mem_arbiter: RTL

Arbitrates single-word read requests from the video pipeline's fetch engines onto the shared 16-bit graphics SPRAM. Sits directly upstream of the background controller and its sibling sprite/overlay fetchers. It uses the same memory channel each of them exposes (`memory_address`, `rvalid`, `memory_data`, `rready`). Clients are granted round-robin, and each SPRAM read returns with a one-cycle `rready` pulse to the granted client.

---
 rtl/gfx_mem_pkg.sv | 14 +
 rtl/gfx_mem_arbiter_rr_picker.sv | 36 +++
 rtl/gfx_mem_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/gfx_mem_pkg.sv
// Shared definitions for the graphics SPRAM arbiter and the
// fetch engines that sit on its client channels.
package gfx_mem_pkg;

  localparam int GFX_ADDR_BITS = 16;
  localparam int GFX_DATA_BITS = 16;

  typedef enum logic [1:0] {
    S_ARB = 2'd0,
    S_MEM = 2'd1,
    S_RET = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gfx_mem_arbiter_rr_picker.sv
// Round-robin find-first: first asserted request at or above
// the pointer, wrapping modulo N_CH.
module rr_picker #(
  parameter int N_CH  = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             grant_valid_o,
  output logic [PTR_W-1:0] grant_idx_o
);

  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;

  // pos carries one spare bit so the wrap compare works
  // for non-power-of-two channel counts
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    pos           = '0;
    idx           = '0;
    for (int k = 0; k < N_CH; k++) begin
      pos = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (pos > (PTR_W+1)'(N_CH-1)) begin
        pos = pos - (PTR_W+1)'(N_CH);
      end
      idx = pos[PTR_W-1:0];
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter placing single-word client reads onto
// the shared graphics SPRAM; one access every three cycles.
import gfx_mem_pkg::*;

module gfx_mem_arbiter #(
  parameter int N_CH      = 4,
  parameter int ADDR_BITS = GFX_ADDR_BITS,
  parameter int DATA_BITS = GFX_DATA_BITS
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic [N_CH*ADDR_BITS-1:0] client_addr,
  input  logic [N_CH-1:0]          client_rvalid,
  output logic [N_CH-1:0]          client_rready,
  output logic [DATA_BITS-1:0]     client_rdata,
  output logic [ADDR_BITS-1:0]     mem_addr,
  output logic                     mem_cs,
  input  logic [DATA_BITS-1:0]     mem_rdata
);

  localparam int PTR_W = $clog2(N_CH);

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      grant_idx_q, grant_idx_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;

  logic                  pick_valid;
  logic [PTR_W-1:0]      pick_idx;
  logic [ADDR_BITS-1:0]  addr_a [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_addr
    assign addr_a[g] =
      client_addr[g*ADDR_BITS +: ADDR_BITS];
  end

  rr_picker #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i         (client_rvalid),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (pick_valid),
    .grant_idx_o   (pick_idx)
  );

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= S_ARB;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    mem_addr_d  = mem_addr_q;
    unique case (state_q)
      S_ARB: begin
        if (pick_valid) begin
          grant_idx_d = pick_idx;
          mem_addr_d  = addr_a[pick_idx];
          state_d     = S_MEM;
        end
      end
      S_MEM: state_d = S_RET;
      S_RET: begin
        // next search starts just past the channel served
        if (grant_idx_q == PTR_W'(N_CH-1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_idx_q + 1'b1;
        end
        state_d = S_ARB;
      end
      default: state_d = S_ARB;
    endcase
  end

  // outputs decode registered state only
  assign mem_cs   = (state_q == S_MEM);
  assign mem_addr = mem_addr_q;
  assign client_rdata = mem_rdata;
  assign client_rready = (state_q == S_RET)
    ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_idx_q)
    : '0;

endmodule
